// File: rtl/pdm_pkg.sv
// Shared CIC/PCM constants, types and the comb-to-PCM conversion for the PDM decimator.
`ifndef MIC_NUMBER
`define MIC_NUMBER 16
`endif

package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int CIC_R     = 64;
  localparam int CIC_W     = 19;
  localparam int PCM_W     = 16;
  localparam int CNT_W     = $clog2(CIC_R);

  typedef logic [CIC_W-1:0]        cic_t;
  typedef logic signed [PCM_W-1:0] pcm_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  localparam cic_t PCM_OFFSET = 19'd131072;
  localparam cnt_t CNT_LAST   = cnt_t'(CIC_R - 1);

  localparam logic signed [CIC_W:0] PCM_MAX = 20'sd32767;
  localparam logic signed [CIC_W:0] PCM_MIN = -20'sd32768;

  // Comb output spans 0..2^18; centre it, drop two LSBs, clip the single +32768 case.
  function automatic pcm_t cic_to_pcm(input cic_t c);
    logic signed [CIC_W:0] centered;
    logic signed [CIC_W:0] shifted;
    centered = $signed({1'b0, c}) - $signed({1'b0, PCM_OFFSET});
    shifted  = centered >>> 2;
    if (shifted > PCM_MAX) begin
      return pcm_t'(PCM_MAX[PCM_W-1:0]);
    end else if (shifted < PCM_MIN) begin
      return pcm_t'(PCM_MIN[PCM_W-1:0]);
    end else begin
      return pcm_t'(shifted[PCM_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_cic3_channel.sv
// One channel of a 3rd-order CIC (R=64, M=1): integrators every clock, combs when dump is high.
// comb_out is combinational and includes the bit presented this cycle; valid only while dump=1.
module cic3_channel
  import pdm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pdm_bit,
  input  logic dump,
  output cic_t comb_out
);

  cic_t integ1, integ2, integ3;
  cic_t integ1_next, integ2_next, integ3_next;
  cic_t delay1, delay2, delay3;
  cic_t comb1, comb2, comb3;

  // Integrator chain is combinational-through so the dump cycle sees its own input bit.
  always_comb begin
    integ1_next = integ1 + {{(CIC_W-1){1'b0}}, pdm_bit};
    integ2_next = integ2 + integ1_next;
    integ3_next = integ3 + integ2_next;
    comb1       = integ3_next - delay1;
    comb2       = comb1 - delay2;
    comb3       = comb2 - delay3;
  end

  assign comb_out = comb3;

  always_ff @(posedge clk) begin
    if (rst) begin
      integ1 <= '0;
      integ2 <= '0;
      integ3 <= '0;
      delay1 <= '0;
      delay2 <= '0;
      delay3 <= '0;
    end else begin
      integ1 <= integ1_next;
      integ2 <= integ2_next;
      integ3 <= integ3_next;
      if (dump) begin
        delay1 <= integ3_next;
        delay2 <= comb1;
        delay3 <= comb2;
      end
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// MIC_NUM-channel PDM-to-PCM CIC decimator (64:1), one-cycle output latency, frame register with valid/ready.
// A frame arriving while the previous one is unconsumed overwrites it; PDM_OVERRUN_EN adds a sticky o_overrun flag.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int MIC_NUM = `MIC_NUMBER
)
(
  input  logic        i_BCLK,
  input  logic        i_rst,
  input  logic        i_mic_data [MIC_NUM],
  input  logic        i_ready,
  output pcm_t        o_pcm      [MIC_NUM],
  output logic        o_valid,
  output logic        o_overrun
);

  cnt_t cnt;
  logic frame_end;
  cic_t comb_out [MIC_NUM];

  assign frame_end = (cnt == CNT_LAST);

  for (genvar ch = 0; ch < MIC_NUM; ch++) begin : g_ch
    cic3_channel u_cic (
      .clk      (i_BCLK),
      .rst      (i_rst),
      .pdm_bit  (i_mic_data[ch]),
      .dump     (frame_end),
      .comb_out (comb_out[ch])
    );
  end

  always_ff @(posedge i_BCLK) begin
    if (i_rst) begin
      cnt     <= '0;
      o_valid <= 1'b0;
      for (int ch = 0; ch < MIC_NUM; ch++) begin
        o_pcm[ch] <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (frame_end) begin
        o_valid <= 1'b1;
        for (int ch = 0; ch < MIC_NUM; ch++) begin
          o_pcm[ch] <= cic_to_pcm(comb_out[ch]);
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef PDM_OVERRUN_EN
  always_ff @(posedge i_BCLK) begin
    if (i_rst) begin
      o_overrun <= 1'b0;
    end else if (frame_end && o_valid && !i_ready) begin
      o_overrun <= 1'b1;
    end
  end
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench: stimulus pushes hand-computed frame expectations, a monitor pops them on each valid&ready.
module tb_pdm_cic_decimator;

  localparam int MIC = 16;
`ifdef PDM_OVERRUN_EN
  localparam int OVR_EXP = 1;
`else
  localparam int OVR_EXP = 0;
`endif

  logic              i_BCLK;
  logic              i_rst;
  logic              i_mic_data [MIC];
  logic              i_ready;
  logic signed [15:0] o_pcm     [MIC];
  logic              o_valid;
  logic              o_overrun;

  typedef struct {
    bit chk;
    int e0;
    int er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pdm_cic_decimator #(.MIC_NUM(MIC)) dut (
    .i_BCLK     (i_BCLK),
    .i_rst      (i_rst),
    .i_mic_data (i_mic_data),
    .i_ready    (i_ready),
    .o_pcm      (o_pcm),
    .o_valid    (o_valid),
    .o_overrun  (o_overrun)
  );

  initial begin
    i_BCLK = 1'b0;
    forever #5 i_BCLK = ~i_BCLK;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Channel 0 expects e0, every other channel expects er.
  task automatic check_pcm(input string name, input int e0, input int er);
    int bad_ch;
    int want;
    bad_ch = -1;
    want   = 0;
    for (int c = MIC - 1; c >= 0; c--) begin
      if (int'(o_pcm[c]) !== ((c == 0) ? e0 : er)) begin
        bad_ch = c;
        want   = (c == 0) ? e0 : er;
      end
    end
    checks++;
    if (bad_ch >= 0) begin
      errors++;
      $display("FAIL %s: ch%0d got %0d expected %0d", name, bad_ch, int'(o_pcm[bad_ch]), want);
    end
  endtask

  task automatic push(input bit chk, input int e0, input int er);
    exp_t e;
    e.chk = chk;
    e.e0  = e0;
    e.er  = er;
    sb.push_back(e);
  endtask

  function automatic logic pat_bit(input int pat, input int k, input int c);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2 == 0);
      default: return (c == 0);
    endcase
  endfunction

  // mode 0: ready always; 1: ready only on bit 0; 2: never; 3: only on bit 63
  task automatic drive_frame(input int pat, input int mode);
    for (int k = 0; k < 64; k++) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (k == 0);
        2:       i_ready = 1'b0;
        default: i_ready = (k == 63);
      endcase
      for (int c = 0; c < MIC; c++) begin
        i_mic_data[c] = pat_bit(pat, k, c);
      end
      @(posedge i_BCLK);
      #2;
    end
  endtask

  task automatic set_all(input logic v);
    for (int c = 0; c < MIC; c++) begin
      i_mic_data[c] = v;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge i_BCLK);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got ch0=%0d expected no frame", int'(o_pcm[0]));
        end else begin
          e = sb.pop_front();
          if (e.chk) check_pcm("frame_pcm", e.e0, e.er);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    i_rst   = 1'b1;
    i_ready = 1'b1;
    set_all(1'b0);
    repeat (3) @(posedge i_BCLK);
    #2;
    check("reset_valid", int'(o_valid), 0);
    check("reset_overrun", int'(o_overrun), 0);
    check_pcm("reset_pcm", 0, 0);
    i_rst = 1'b0;

    // All ones from a clean start: C = 45760, 220480, then 262144 (clipped)
    push(1, -21328, -21328); drive_frame(1, 0);
    push(1, 22352, 22352);   drive_frame(1, 0);
    for (int f = 0; f < 3; f++) begin
      push(1, 32767, 32767); drive_frame(1, 0);
    end

    i_rst = 1'b1;
    set_all(1'b0);
    repeat (2) @(posedge i_BCLK);
    #2;
    i_rst = 1'b0;

    for (int f = 0; f < 3; f++) begin
      push(1, -32768, -32768); drive_frame(0, 0);
    end

    // Alternating: first two frames are transient
    push(0, 0, 0); drive_frame(2, 0);
    push(0, 0, 0); drive_frame(2, 0);
    push(1, 0, 0); drive_frame(2, 0);
    push(1, 0, 0); drive_frame(2, 0);

    // Channel independence
    push(0, 0, 0); drive_frame(3, 0);
    push(0, 0, 0); drive_frame(3, 0);
    push(1, 32767, -32768); drive_frame(3, 0);
    push(1, 32767, -32768); drive_frame(3, 0);

    // Ready asserted only on the bit-63 edge; new frame is first zeros frame after ones
    push(1, 32767, -32768); drive_frame(3, 1);
    push(1, 21328, -32768); drive_frame(0, 3);
    check("ready_on_last_valid", int'(o_valid), 1);
    check("ready_on_last_overrun", int'(o_overrun), 0);
    check_pcm("ready_on_last_pcm", 21328, -32768);

    // Ready low across two frame boundaries: second frame (-22352 on ch0) is overwritten
    drive_frame(0, 1);
    push(1, -32768, -32768); drive_frame(0, 2);
    check("overrun_valid", int'(o_valid), 1);
    check("overrun_flag", int'(o_overrun), OVR_EXP);
    check_pcm("overrun_pcm", -32768, -32768);

    // Reset mid-frame at counter 30
    i_ready = 1'b1;
    set_all(1'b1);
    for (int k = 0; k < 30; k++) begin
      @(posedge i_BCLK);
      #2;
    end
    i_rst = 1'b1;
    @(posedge i_BCLK);
    #2;
    check("midreset_valid", int'(o_valid), 0);
    check("midreset_overrun", int'(o_overrun), 0);
    check_pcm("midreset_pcm", 0, 0);
    i_rst = 1'b0;
    push(1, -21328, -21328);
    n = 0;
    while (n < 100 && !o_valid) begin
      @(posedge i_BCLK);
      #2;
      n++;
    end
    check("rst_release_latency", n, 64);

    @(posedge i_BCLK);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter MIC_NUM, default `MIC_NUMBER (16), number of PDM microphone channels.
REQ-002 SHALL have port i_BCLK  input  1  single clock, 3.2 MHz PDM bit clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_mic_data  input  1 x MIC_NUM (unpacked array, index 0..MIC_NUM-1)  one PDM bit per channel, sampled every clock.
REQ-005 SHALL have port i_ready  input  1  consumer accepts the current frame.
REQ-006 SHALL have port o_pcm  output  16 x MIC_NUM (unpacked), signed  decimated PCM sample per channel.
REQ-007 SHALL have port o_valid  output  1  o_pcm holds an unconsumed frame.
REQ-008 SHALL have port o_overrun  output  1  sticky: an unconsumed frame was overwritten.

Function
REQ-009 SHALL implement per channel a 3rd-order CIC, R=64, M=1, giving a 50 kHz output rate.
REQ-010 SHALL map PDM bit 1 -> 1 and bit 0 -> 0 (unsigned input to the integrators).
REQ-011 SHALL use 19-bit integrators and combs with modulo-2^19 wrap-around, no saturation inside the CIC.
REQ-012 SHALL keep a 6-bit decimation counter, 0..63, incremented every clock and wrapping 63 -> 0.
REQ-013 SHALL run the comb stages once per frame, on the cycle the counter is 63, using the integrator value that includes that cycle's bit.
REQ-014 SHALL convert comb output C (0..262144) to pcm = sat16((C - 131072) >>> 2); 32768 saturates to 32767, lower bound -32768.
REQ-015 SHALL load o_pcm and set o_valid on the clock edge that samples bit 63 (one-cycle output latency); all channels load together.
REQ-016 SHALL clear o_valid on an edge where o_valid=1 and i_ready=1 and no new frame loads.
REQ-017 SHALL, if a new frame loads while o_valid=1 and i_ready=0, overwrite o_pcm, keep o_valid=1, and set o_overrun.
REQ-018 SHALL, if a new frame loads on the same edge that i_ready=1, load the new frame, keep o_valid=1, and leave o_overrun unchanged.
REQ-019 SHALL keep o_pcm stable while o_valid=1 except when a new frame loads.

Reset
REQ-020 SHALL on i_rst=1 clear integrators, comb delays, counter, o_pcm (all 0), o_valid (0) and o_overrun (0).
REQ-021 SHALL, on reset asserted mid-frame, discard the partial frame; the first frame after release completes 64 cycles after release.
REQ-022 SHALL clear o_overrun only by reset.

Configuration
REQ-023 SHALL, with macro PDM_OVERRUN_EN defined, implement the o_overrun logic of REQ-017/REQ-022.
REQ-024 SHALL, without PDM_OVERRUN_EN, keep port o_overrun, tie it to 0 and include no overrun register; all other behaviour is unchanged.

Structure
REQ-025 SHALL place CIC_ORDER=3, CIC_R=64, CIC_W=19, PCM_W=16 and the offset constant 131072 in a shared package, pdm_pkg.
REQ-026 SHALL instantiate one sub-module, cic3_channel, per channel, holding the integrators and comb delays; the counter, output register and handshake are shared in the parent.

Verification
REQ-027 SHALL verify all-ones on every channel: frames 3 and later give o_pcm = 32767.
REQ-028 SHALL verify all-zeros on every channel: frames 3 and later give o_pcm = -32768.
REQ-029 SHALL verify the alternating pattern 1,0,1,0...: frames 3 and later give o_pcm = 0, and channel independence by driving channel 0 with all ones and the others with zeros (ch0 = 32767, others = -32768).
REQ-030 SHALL verify i_ready held at 0 across two frame boundaries: o_valid=1, o_pcm equals the second frame, and o_overrun=1 (0 when PDM_OVERRUN_EN is undefined).
REQ-031 SHALL verify i_ready=1 on exactly the bit-63 edge: the new frame loads, o_valid stays 1, o_overrun stays 0.
REQ-032 SHALL verify i_rst pulsed at counter=30: all outputs go to 0, and the next o_valid rises 64 cycles after reset release.
